// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and load/store requesters. Only one
// transaction is in flight at a time. Data normally wins a conflict, but a
// streak counter limits how many data grants can pass a waiting fetch.
module mem_port_arbiter #(
    parameter int AW          = 30,
    parameter int DW          = 64,
    parameter int MAX_DSTREAK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ready,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ready,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            err
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_I,
        ISSUE_D,
        WAIT_I,
        WAIT_D
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  streak_q, streak_d;
    logic           err_q, err_d;

    logic           arb;
    logic           d_elig;
    logic           i_win;
    logic           d_win;
    logic           in_issue;
    logic           in_wait;

    // Next state, streak/error update and all combinational port outputs.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        err_d    = err_q;
        arb      = 1'b0;
        d_elig   = d_req;
        i_win    = 1'b0;
        d_win    = 1'b0;
        in_issue = (state_q == ISSUE_I) || (state_q == ISSUE_D);
        in_wait  = (state_q == WAIT_I) || (state_q == WAIT_D);

        m_req    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_be     = '0;
        i_ready  = 1'b0;
        d_ready  = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;

        case (state_q)
            IDLE: begin
                arb = 1'b1;
            end
            ISSUE_I: begin
                m_req   = 1'b1;
                m_addr  = i_addr;
                m_be    = '1;
                i_ready = m_gnt;
                if (m_gnt) begin
                    state_d = WAIT_I;
                end
            end
            ISSUE_D: begin
                m_req   = 1'b1;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_be    = d_be;
                d_ready = m_gnt;
                if (m_gnt) begin
                    if (d_we) begin
                        // The accepted write is still on d_req this cycle;
                        // masking it stops it being granted twice.
                        arb    = 1'b1;
                        d_elig = 1'b0;
                    end else begin
                        state_d = WAIT_D;
                    end
                end
            end
            WAIT_I: begin
                i_rvalid = m_rvalid;
                if (m_rvalid) begin
                    i_rdata = m_rdata;
                    arb     = 1'b1;
                end
            end
            WAIT_D: begin
                d_rvalid = m_rvalid;
                if (m_rvalid) begin
                    d_rdata = m_rdata;
                    arb     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (arb) begin
            i_win = i_req && (!d_elig || (streak_q == STREAK_MAX));
            d_win = d_elig && !i_win;
            if (d_win) begin
                state_d = ISSUE_D;
                // A data win that passes a waiting fetch extends the streak;
                // it cannot exceed the limit because fetch wins at the limit.
                if (i_req) begin
                    streak_d = streak_q + SW'(1);
                end
            end else if (i_win) begin
                state_d  = ISSUE_I;
                streak_d = '0;
            end else begin
                state_d = IDLE;
            end
        end

        if ((m_rvalid && !in_wait) || (m_gnt && !in_issue)) begin
            err_d = 1'b1;
        end

        // Reset takes precedence over any handshake seen in the same cycle.
        if (reset) begin
            m_req    = 1'b0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            m_be     = '0;
            i_ready  = 1'b0;
            d_ready  = 1'b0;
            i_rvalid = 1'b0;
            d_rvalid = 1'b0;
            i_rdata  = '0;
            d_rdata  = '0;
        end
    end

    // State, streak and sticky error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by constrained-random traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW   = 30;
    localparam int DW   = 64;
    localparam int BW   = DW / 8;
    localparam int MAXS = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_ready;
    logic            i_rvalid;
    logic [DW-1:0]   i_rdata;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [BW-1:0]   d_be;
    logic            d_ready;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;
    logic            m_req;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [BW-1:0]   m_be;
    logic            m_gnt;
    logic            m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            err;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: the single in-flight transaction, its owner,
    // whether memory has accepted it, plus the streak count and error flag.
    bit mdl_busy;
    bit mdl_owner_d;
    bit mdl_granted;
    int mdl_streak;
    bit mdl_err;

    // Expected outputs for the current cycle (also steer the random agents).
    logic          exp_m_req, exp_m_we, exp_i_ready, exp_d_ready;
    logic          exp_i_rv, exp_d_rv;
    logic [AW-1:0] exp_m_addr;
    logic [DW-1:0] exp_m_wdata, exp_i_rdata, exp_d_rdata;
    logic [BW-1:0] exp_m_be;

    // Random agent state.
    bit i_pend, i_out, d_pend, d_out, d_gap, mem_pend;
    int mem_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for inputs to settle, derive expected outputs, compare.
    task automatic settle();
        bit issue, waiting;
        #1;
        issue   = !reset && mdl_busy && !mdl_granted;
        waiting = !reset && mdl_busy && mdl_granted;
        exp_m_req   = issue;
        exp_m_we    = 1'b0;
        exp_m_addr  = '0;
        exp_m_wdata = '0;
        exp_m_be    = '0;
        if (issue && !mdl_owner_d) begin
            exp_m_addr = i_addr;
            exp_m_be   = '1;
        end else if (issue) begin
            exp_m_we    = d_we;
            exp_m_addr  = d_addr;
            exp_m_wdata = d_wdata;
            exp_m_be    = d_be;
        end
        exp_i_ready = issue && !mdl_owner_d && m_gnt;
        exp_d_ready = issue && mdl_owner_d && m_gnt;
        exp_i_rv    = waiting && !mdl_owner_d && m_rvalid;
        exp_d_rv    = waiting && mdl_owner_d && m_rvalid;
        exp_i_rdata = exp_i_rv ? m_rdata : '0;
        exp_d_rdata = exp_d_rv ? m_rdata : '0;

        chk("m_req", 64'(m_req), 64'(exp_m_req));
        if (!waiting) begin
            chk("m_we", 64'(m_we), 64'(exp_m_we));
            chk("m_addr", 64'(m_addr), 64'(exp_m_addr));
            chk("m_wdata", 64'(m_wdata), 64'(exp_m_wdata));
            chk("m_be", 64'(m_be), 64'(exp_m_be));
        end
        chk("ready", 64'({i_ready, d_ready}), 64'({exp_i_ready, exp_d_ready}));
        chk("rvalid", 64'({i_rvalid, d_rvalid}), 64'({exp_i_rv, exp_d_rv}));
        chk("i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
        chk("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
        chk("err", 64'(err), 64'(mdl_err));
    endtask

    // Advance the model to the state the next clock edge should produce.
    task automatic mdl_step();
        bit arb, d_el, issue, waiting;
        if (reset) begin
            mdl_busy    = 1'b0;
            mdl_granted = 1'b0;
            mdl_streak  = 0;
            mdl_err     = 1'b0;
            return;
        end
        issue   = mdl_busy && !mdl_granted;
        waiting = mdl_busy && mdl_granted;
        if ((m_rvalid && !waiting) || (m_gnt && !issue)) mdl_err = 1'b1;
        arb  = 1'b0;
        d_el = d_req;
        if (!mdl_busy) begin
            arb = 1'b1;
        end else if (issue) begin
            if (m_gnt) begin
                if (mdl_owner_d && d_we) begin
                    arb  = 1'b1;
                    d_el = 1'b0;
                end else begin
                    mdl_granted = 1'b1;
                end
            end
        end else if (m_rvalid) begin
            arb = 1'b1;
        end
        if (arb) begin
            mdl_granted = 1'b0;
            if (d_el && (!i_req || mdl_streak < MAXS)) begin
                mdl_busy    = 1'b1;
                mdl_owner_d = 1'b1;
                if (i_req) mdl_streak = (mdl_streak < MAXS) ? mdl_streak + 1 : MAXS;
            end else if (i_req) begin
                mdl_busy    = 1'b1;
                mdl_owner_d = 1'b0;
                mdl_streak  = 0;
            end else begin
                mdl_busy = 1'b0;
            end
        end
    endtask

    task automatic adv();
        mdl_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        reset = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    // One cycle of random traffic from protocol-abiding requesters and memory.
    task automatic rand_cycle();
        bit issue_now;
        reset = ($urandom_range(0, 199) == 0);
        if (!i_pend && !i_out && $urandom_range(0, 2) == 0) begin
            i_pend = 1'b1;
            i_addr = AW'($urandom);
        end
        i_req = i_pend;
        if (d_gap) begin
            d_gap = 1'b0;
        end else if (!d_pend && !d_out && $urandom_range(0, 2) == 0) begin
            d_pend  = 1'b1;
            d_we    = 1'($urandom);
            d_addr  = AW'($urandom);
            d_wdata = {$urandom, $urandom};
            d_be    = BW'($urandom);
        end
        d_req = d_pend;
        issue_now = mdl_busy && !mdl_granted && !reset;
        m_gnt     = issue_now && ($urandom_range(0, 1) == 0);
        m_rvalid  = mem_pend && (mem_cnt == 0);
        m_rdata   = {$urandom, $urandom};
        if (!mdl_busy && !reset && $urandom_range(0, 299) == 0) begin
            if ($urandom_range(0, 1) == 0) m_rvalid = 1'b1;
            else m_gnt = 1'b1;
        end
        settle();
        if (reset) begin
            i_pend = 0; i_out = 0; d_pend = 0; d_out = 0; d_gap = 0; mem_pend = 0;
        end else begin
            if (i_pend && exp_i_ready) begin i_pend = 0; i_out = 1; end
            if (i_out && exp_i_rv) i_out = 0;
            if (d_pend && exp_d_ready) begin
                d_pend = 0;
                d_gap  = 1;
                if (!d_we) d_out = 1;
            end
            if (d_out && exp_d_rv) d_out = 0;
            if (m_rvalid && mem_pend) mem_pend = 0;
            else if (mem_pend && mem_cnt > 0) mem_cnt--;
            if (exp_m_req && m_gnt && !exp_m_we) begin
                mem_pend = 1;
                mem_cnt  = $urandom_range(0, 2);
            end
        end
        adv();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        settle(); adv();
        settle(); adv();
        reset = 1'b0;
        settle();
        chk("rst_m_req", 64'(m_req), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        adv();

        // Single fetch read.
        i_req = 1'b1; i_addr = 30'h10;
        settle(); chk("t1_idle_mreq", 64'(m_req), 64'(0)); adv();
        m_gnt = 1'b1;
        settle();
        chk("t1_mreq", 64'(m_req), 64'(1));
        chk("t1_maddr", 64'(m_addr), 64'h10);
        chk("t1_iready", 64'(i_ready), 64'(1));
        adv();
        i_req = 1'b0; m_gnt = 1'b0;
        settle(); chk("t1_wait_mreq", 64'(m_req), 64'(0)); adv();
        m_rvalid = 1'b1; m_rdata = 64'h1122334455667788;
        settle();
        chk("t1_irvalid", 64'(i_rvalid), 64'(1));
        chk("t1_irdata", 64'(i_rdata), 64'h1122334455667788);
        adv();
        m_rvalid = 1'b0;
        settle(); chk("t1_back_idle", 64'(m_req), 64'(0)); adv();

        // Simultaneous requests: data first, fetch follows without a bubble.
        i_req = 1'b1; i_addr = 30'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'h20;
        settle(); adv();
        m_gnt = 1'b1;
        settle();
        chk("t2_maddr_d", 64'(m_addr), 64'h20);
        chk("t2_dready", 64'(d_ready), 64'(1));
        adv();
        d_req = 1'b0; m_gnt = 1'b0;
        settle(); adv();
        m_rvalid = 1'b1; m_rdata = 64'hCAFE0000BEEF1111;
        settle();
        chk("t2_drdata", 64'(d_rdata), 64'hCAFE0000BEEF1111);
        adv();
        m_rvalid = 1'b0; m_gnt = 1'b1;
        settle();
        chk("t2_no_bubble", 64'(m_req), 64'(1));
        chk("t2_maddr_i", 64'(m_addr), 64'h44);
        adv();
        i_req = 1'b0; m_gnt = 1'b0;
        settle(); adv();
        m_rvalid = 1'b1; settle(); adv();
        m_rvalid = 1'b0; settle(); adv();

        // Granted write with fetch waiting: the write stays masked, fetch goes next.
        i_req = 1'b1; i_addr = 30'h30;
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'h31; d_wdata = 64'h5; d_be = 8'hFF;
        settle(); adv();
        m_gnt = 1'b1;
        settle(); chk("t3_dready", 64'(d_ready), 64'(1)); adv();
        d_req = 1'b0;
        settle();
        chk("t3_fetch_next", 64'(m_addr), 64'h30);
        chk("t3_iready", 64'(i_ready), 64'(1));
        adv();
        i_req = 1'b0; m_gnt = 1'b0;
        settle(); adv();
        m_rvalid = 1'b1; settle(); adv();
        m_rvalid = 1'b0; settle(); adv();

        // Write held for three cycles before the grant.
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'h55; d_wdata = 64'hDEADBEEF; d_be = 8'h0F;
        settle(); adv();
        for (int k = 0; k < 4; k++) begin
            m_gnt = (k == 3);
            settle();
            chk("t4_mreq", 64'(m_req), 64'(1));
            chk("t4_mwdata", 64'(m_wdata), 64'hDEADBEEF);
            chk("t4_mbe", 64'(m_be), 64'h0F);
            chk("t4_dready", 64'(d_ready), 64'(k == 3));
            adv();
        end
        d_req = 1'b0; m_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("t4_no_drvalid", 64'(d_rvalid), 64'(0)); adv();
        end

        // Stray read data in IDLE sets the sticky error.
        m_rvalid = 1'b1; m_rdata = 64'h77;
        settle(); chk("t5_no_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0)); adv();
        m_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("t5_err_sticky", 64'(err), 64'(1)); adv();
        end
        reset = 1'b1; settle(); adv();
        reset = 1'b0;
        settle(); chk("t5_err_cleared", 64'(err), 64'(0)); adv();

        // Reset during a data read wait, coinciding with read data.
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'h66;
        settle(); adv();
        m_gnt = 1'b1; settle(); adv();
        d_req = 1'b0; m_gnt = 1'b0; settle(); adv();
        reset = 1'b1; m_rvalid = 1'b1; m_rdata = 64'h99;
        settle(); chk("t6_reset_wins", 64'(d_rvalid), 64'(0)); adv();
        reset = 1'b0; m_rvalid = 1'b0;
        settle(); chk("t6_idle_after", 64'(m_req), 64'(0));
        chk("t6_err", 64'(err), 64'(0));
        i_req = 1'b1; i_addr = 30'h77;
        adv();
        m_gnt = 1'b1;
        settle(); chk("t6_fetch_addr", 64'(m_addr), 64'h77); adv();
        i_req = 1'b0; m_gnt = 1'b0; settle(); adv();
        m_rvalid = 1'b1; m_rdata = 64'hA5A5A5A5A5A5A5A5;
        settle(); chk("t6_fetch_data", 64'(i_rdata), 64'hA5A5A5A5A5A5A5A5); adv();
        clear_inputs();
        settle(); adv();

        // Random traffic.
        i_pend = 0; i_out = 0; d_pend = 0; d_out = 0; d_gap = 0; mem_pend = 0; mem_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            rand_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
